// File: rtl/timer_ctrl_pkg.sv
// Shared types and default sizes for the timer controller.
package timer_ctrl_pkg;

   localparam int DEF_WIDTH   = 4;
   localparam int DEF_PRESC_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      OP_NOP   = 2'd0,
      OP_START = 2'd1,
      OP_PAUSE = 2'd2,
      OP_STOP  = 2'd3
   } cmd_op_e;

endpackage

// File: rtl/timer_prescaler.sv
// Programmable prescaler: while enabled, emits a tick every presc+1 cycles.
// clear has priority over en and restarts the phase at 0. The count holds
// while en is low, so pausing preserves the phase.
module timer_prescaler #(
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               clear,
   input  logic [PRESC_W-1:0] presc,
   output logic               tick
);

   logic [PRESC_W-1:0] cnt;

   assign tick = en && (cnt == presc);

   // Phase counter: wraps to 0 on the tick, freezes when disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (en)
         cnt <= tick ? '0 : cnt + PRESC_W'(1);
   end

endmodule

// File: rtl/timer_ctrl.sv
// Command-driven timer controller: START / PAUSE_TOGGLE / STOP over a
// valid/ready port, one-shot or periodic counting to a terminal count.
// Optional feature macro: TIMER_CTRL_IRQ_EN adds a sticky irq with irq_clr.
module timer_ctrl
   import timer_ctrl_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int PRESC_W = DEF_PRESC_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [WIDTH-1:0]   cmd_term,
   input  logic [PRESC_W-1:0] cmd_presc,
   input  logic               cmd_periodic,
   output logic [WIDTH-1:0]   cnt_out,
   output logic               busy,
   output logic               done,
`ifdef TIMER_CTRL_IRQ_EN
   output logic               irq,
   input  logic               irq_clr,
`endif
   output logic               tc_pulse
);

   state_e             state_q, state_d;
   cmd_op_e            op;
   logic [WIDTH-1:0]   term_reg;
   logic [PRESC_W-1:0] presc_reg;
   logic               periodic_reg;
   logic [WIDTH-1:0]   cnt_d;
   logic               accept;
   logic               load;
   logic               pre_clr;
   logic               tick;
   logic               tc_d;

   assign op     = cmd_op_e'(cmd_op);
   assign accept = cmd_valid && cmd_ready;

   timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
      .clk   (clk),
      .rst   (rst),
      .en    (state_q == ST_RUN),
      .clear (pre_clr),
      .presc (presc_reg),
      .tick  (tick)
   );

   // Next state / count. An accepted command always wins over a tick in the
   // same cycle; the tick is then dropped (no increment, no tc_pulse).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_out;
      tc_d    = 1'b0;
      load    = 1'b0;
      pre_clr = 1'b0;
      if (accept) begin
         unique case (op)
            OP_START: begin
               load    = 1'b1;
               pre_clr = 1'b1;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
            OP_PAUSE: begin
               if (state_q == ST_RUN)
                  state_d = ST_PAUSE;
               else if (state_q == ST_PAUSE)
                  state_d = ST_RUN;
            end
            OP_STOP: begin
               pre_clr = 1'b1;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
            default: ;
         endcase
      end else if (tick) begin
         if (cnt_out == term_reg) begin
            tc_d = 1'b1;
            if (periodic_reg)
               cnt_d = '0;
            else
               state_d = ST_DONE;
         end else begin
            cnt_d = cnt_out + WIDTH'(1);
         end
      end
   end

   // State register and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_out   <= '0;
         tc_pulse  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cmd_ready <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_out   <= cnt_d;
         tc_pulse  <= tc_d;
         busy      <= (state_d == ST_RUN) || (state_d == ST_PAUSE);
         done      <= (state_d == ST_DONE);
         cmd_ready <= !accept;
      end
   end

   // Configuration captured on START.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         term_reg     <= '0;
         presc_reg    <= '0;
         periodic_reg <= 1'b0;
      end else if (load) begin
         term_reg     <= cmd_term;
         presc_reg    <= cmd_presc;
         periodic_reg <= cmd_periodic;
      end
   end

`ifdef TIMER_CTRL_IRQ_EN
   // Sticky interrupt: set by tc_pulse, cleared by irq_clr; set wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         irq <= 1'b0;
      else
         irq <= tc_pulse | (irq & ~irq_clr);
   end
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed commands, a behavioural model checked every
// cycle, and hand-computed literal expectations. Honours TIMER_CTRL_IRQ_EN.
module tb_timer_ctrl;

   localparam int WIDTH   = 4;
   localparam int PRESC_W = 8;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               cmd_valid = 1'b0;
   logic               cmd_ready;
   logic [1:0]         cmd_op = 2'd0;
   logic [WIDTH-1:0]   cmd_term = '0;
   logic [PRESC_W-1:0] cmd_presc = '0;
   logic               cmd_periodic = 1'b0;
   logic [WIDTH-1:0]   cnt_out;
   logic               busy, done, tc_pulse;
   logic               irq;
   logic               irq_clr = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   timer_ctrl #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_term     (cmd_term),
      .cmd_presc    (cmd_presc),
      .cmd_periodic (cmd_periodic),
      .cnt_out      (cnt_out),
      .busy         (busy),
      .done         (done),
`ifdef TIMER_CTRL_IRQ_EN
      .irq          (irq),
      .irq_clr      (irq_clr),
`endif
      .tc_pulse     (tc_pulse)
   );

`ifndef TIMER_CTRL_IRQ_EN
   assign irq = 1'b0;
`endif

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Mode: 0 idle, 1 counting, 2 paused, 3 finished.
   int m_mode, m_cnt, m_phase, m_term, m_presc;
   bit m_per, m_ready, m_tc, m_irq;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode = 0; m_cnt = 0; m_phase = 0; m_term = 0; m_presc = 0;
         m_per = 0; m_ready = 1; m_tc = 0; m_irq = 0;
      end else begin
         bit acc, tk;
         int nmode, ncnt, nphase;
         acc    = cmd_valid && m_ready;
         tk     = (m_mode == 1) && (m_phase == m_presc);
         nmode  = m_mode;
         ncnt   = m_cnt;
         nphase = m_phase;
         if (m_mode == 1) nphase = (m_phase + 1) % (m_presc + 1);
         m_irq = m_tc || (m_irq && !irq_clr);
         m_tc  = 0;
         if (acc) begin
            if (cmd_op == 2'd1) begin
               m_term = int'(cmd_term); m_presc = int'(cmd_presc); m_per = cmd_periodic;
               ncnt = 0; nphase = 0; nmode = 1;
            end else if (cmd_op == 2'd2) begin
               if (m_mode == 1) nmode = 2;
               else if (m_mode == 2) nmode = 1;
            end else if (cmd_op == 2'd3) begin
               ncnt = 0; nphase = 0; nmode = 0;
            end
         end else if (tk) begin
            if (m_cnt == m_term) begin
               m_tc = 1;
               if (m_per) ncnt = 0; else nmode = 3;
            end else begin
               ncnt = m_cnt + 1;
            end
         end
         m_mode = nmode; m_cnt = ncnt; m_phase = nphase;
         m_ready = !acc;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         chk("cmp cnt_out", int'(cnt_out), m_cnt);
         chk("cmp busy", int'(busy), int'(m_mode == 1 || m_mode == 2));
         chk("cmp done", int'(done), int'(m_mode == 3));
         chk("cmp tc_pulse", int'(tc_pulse), int'(m_tc));
         chk("cmp cmd_ready", int'(cmd_ready), int'(m_ready));
`ifdef TIMER_CTRL_IRQ_EN
         chk("cmp irq", int'(irq), int'(m_irq));
`endif
      end
   end

   // Present one command for a single edge; returns at the following negedge.
   task automatic issue(input logic [1:0] op, input int term, input int presc, input bit per);
      int w = 0;
      while (!cmd_ready && w < 10) begin @(negedge clk); w++; end
      if (!cmd_ready) chk("issue ready timeout", 0, 1);
      cmd_valid = 1'b1; cmd_op = op;
      cmd_term = term[WIDTH-1:0]; cmd_presc = presc[PRESC_W-1:0]; cmd_periodic = per;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_op = 2'd0;
   endtask

   task automatic wait_tc(input string name);
      int w = 0;
      while (!tc_pulse && w < 20) begin @(negedge clk); w++; end
      if (!tc_pulse) chk(name, 0, 1);
   endtask

   int seq_exp [7] = '{0, 0, 1, 1, 2, 2, 0};
   int pulses;

   initial begin
      // Reset state
      #1 rst = 1'b1;
      #2;
      chk("reset cnt_out", int'(cnt_out), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset cmd_ready", int'(cmd_ready), 1);
      chk("reset done", int'(done), 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // One-shot term=3 presc=0
      issue(2'd1, 3, 0, 1'b0);
      chk("os start cnt", int'(cnt_out), 0);
      chk("os start busy", int'(busy), 1);
      chk("os ready low", int'(cmd_ready), 0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("os count", int'(cnt_out), k);
      end
      @(negedge clk);
      chk("os done", int'(done), 1);
      chk("os tc", int'(tc_pulse), 1);
      chk("os hold", int'(cnt_out), 3);
      chk("os busy off", int'(busy), 0);
      @(negedge clk);
      chk("os tc once", int'(tc_pulse), 0);
      chk("os hold2", int'(cnt_out), 3);

      // Periodic term=2 presc=1
      issue(2'd1, 2, 1, 1'b1);
      chk("per seq0", int'(cnt_out), seq_exp[0]);
      pulses = 0;
      for (int i = 1; i <= 18; i++) begin
         @(negedge clk);
         if (i <= 6) chk("per seq", int'(cnt_out), seq_exp[i]);
         if (tc_pulse) pulses++;
      end
      chk("per pulses in 18", pulses, 3);

      // Pause at cnt_out=1, hold 5 cycles, resume
      begin
         int w = 0;
         while (cnt_out != 4'd1 && w < 10) begin @(negedge clk); w++; end
         chk("reach cnt 1", int'(cnt_out), 1);
      end
      issue(2'd2, 0, 0, 1'b0);
      chk("pause busy", int'(busy), 1);
      chk("pause ready low", int'(cmd_ready), 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("paused cnt", int'(cnt_out), 1);
      end
      chk("paused ready back", int'(cmd_ready), 1);
      issue(2'd2, 0, 0, 1'b0);
      chk("resume ready low", int'(cmd_ready), 0);
      chk("resume cnt", int'(cnt_out), 1);
      @(negedge clk); chk("resume phase +1", int'(cnt_out), 2);
      @(negedge clk); chk("resume phase +2", int'(cnt_out), 2);
      @(negedge clk); chk("resume wrap", int'(cnt_out), 0);
      chk("resume tc", int'(tc_pulse), 1);

      // STOP coincident with the terminal tick
      issue(2'd1, 1, 0, 1'b0);
      @(negedge clk);
      chk("stop pre cnt", int'(cnt_out), 1);
      issue(2'd3, 0, 0, 1'b0);
      chk("stop cnt", int'(cnt_out), 0);
      chk("stop busy", int'(busy), 0);
      chk("stop done", int'(done), 0);
      chk("stop no tc", int'(tc_pulse), 0);
      @(negedge clk);
      chk("stop no tc later", int'(tc_pulse), 0);

      // Asynchronous reset mid-run
      issue(2'd1, 5, 0, 1'b1);
      @(negedge clk); @(negedge clk);
      chk("mid cnt 2", int'(cnt_out), 2);
      #2 rst = 1'b1;
      #1;
      chk("async rst cnt", int'(cnt_out), 0);
      chk("async rst busy", int'(busy), 0);
      chk("async rst ready", int'(cmd_ready), 1);
      @(negedge clk);
      rst = 1'b0;

`ifdef TIMER_CTRL_IRQ_EN
      // Sticky irq: set wins over clear, clear alone drops it
      issue(2'd1, 0, 3, 1'b1);
      chk("irq idle", int'(irq), 0);
      wait_tc("irq first tc timeout");
      @(negedge clk);
      chk("irq set", int'(irq), 1);
      @(negedge clk);
      wait_tc("irq second tc timeout");
      irq_clr = 1'b1;
      @(negedge clk);
      irq_clr = 1'b0;
      chk("irq set wins", int'(irq), 1);
      irq_clr = 1'b1;
      @(negedge clk);
      irq_clr = 1'b0;
      chk("irq cleared", int'(irq), 0);
      issue(2'd3, 0, 0, 1'b0);
`endif

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
